// File: rtl/tx_flow_ctrl.sv
// Strobe sequencer for the TX path (main -> VC0/VC1 -> D0/D1 FIFOs): latches thresholds in INIT,
// issues pops when the downstream FIFO has room, pushes one cycle later, and drives backpressure.
module tx_flow_ctrl #(
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             RESET_L,
  input  logic             init,
  input  logic [CNT_W-1:0] main_fifo_low,
  input  logic [CNT_W-1:0] main_fifo_high,
  input  logic [CNT_W-1:0] Vco_low,
  input  logic [CNT_W-1:0] Vco_high,
  input  logic [CNT_W-1:0] Vc1_low,
  input  logic [CNT_W-1:0] Vc1_high,
  input  logic [CNT_W-1:0] Do_low,
  input  logic [CNT_W-1:0] Do_high,
  input  logic [CNT_W-1:0] D1_low,
  input  logic [CNT_W-1:0] D1_high,
  input  logic [CNT_W-1:0] main_cnt,
  input  logic [CNT_W-1:0] vc0_cnt,
  input  logic [CNT_W-1:0] vc1_cnt,
  input  logic [CNT_W-1:0] d0_cnt,
  input  logic [CNT_W-1:0] d1_cnt,
  input  logic             main_head_vc,
  input  logic             vc0_head_dst,
  input  logic             vc1_head_dst,
  output logic             pop_main,
  output logic             push_vc0,
  output logic             push_vc1,
  output logic             pop_vc0,
  output logic             pop_vc1,
  output logic             push_d0,
  output logic             push_d1,
  output logic             main_pause,
  output logic [2:0]       state,
  output logic             idle_out,
  output logic             error_out
);

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StInit   = 3'd1,
    StIdle   = 3'd2,
    StActive = 3'd3,
    StError  = 3'd4
  } state_e;

  localparam int NumFifo = 5;
  localparam logic [CNT_W:0] DepthLim = (CNT_W+1)'(FIFO_DEPTH);

  state_e state_q, state_d;
  logic [CNT_W-1:0] lo_q [NumFifo];
  logic [CNT_W-1:0] hi_q [NumFifo];
  logic [CNT_W-1:0] lo_d [NumFifo];
  logic [CNT_W-1:0] hi_d [NumFifo];
  logic [CNT_W-1:0] lo_in [NumFifo];
  logic [CNT_W-1:0] hi_in [NumFifo];
  logic [CNT_W-1:0] cnt [NumFifo];

  logic push_vc0_q, push_vc1_q, push_d0_q, push_d1_q;
  logic push_vc0_d, push_vc1_d, push_d0_d, push_d1_d;
  logic pause_q, pause_d;

  logic [CNT_W:0] eff_vc0, eff_vc1, eff_d0, eff_d1;
  logic afull_vc0, afull_vc1, afull_d0, afull_d1;
  logic active, pop_main_c, pop_vc0_c, pop_vc1_c;
  logic over, all_empty, push_busy, thr_ok;

  // Index order: 0 main, 1 VC0, 2 VC1, 3 D0, 4 D1
  assign lo_in[0] = main_fifo_low;
  assign hi_in[0] = main_fifo_high;
  assign lo_in[1] = Vco_low;
  assign hi_in[1] = Vco_high;
  assign lo_in[2] = Vc1_low;
  assign hi_in[2] = Vc1_high;
  assign lo_in[3] = Do_low;
  assign hi_in[3] = Do_high;
  assign lo_in[4] = D1_low;
  assign hi_in[4] = D1_high;
  assign cnt[0]   = main_cnt;
  assign cnt[1]   = vc0_cnt;
  assign cnt[2]   = vc1_cnt;
  assign cnt[3]   = d0_cnt;
  assign cnt[4]   = d1_cnt;

  // A push already committed for this cycle is not yet visible in the occupancy count.
  assign eff_vc0 = {1'b0, vc0_cnt} + {{CNT_W{1'b0}}, push_vc0_q};
  assign eff_vc1 = {1'b0, vc1_cnt} + {{CNT_W{1'b0}}, push_vc1_q};
  assign eff_d0  = {1'b0, d0_cnt} + {{CNT_W{1'b0}}, push_d0_q};
  assign eff_d1  = {1'b0, d1_cnt} + {{CNT_W{1'b0}}, push_d1_q};

  assign afull_vc0 = eff_vc0 >= {1'b0, hi_q[1]};
  assign afull_vc1 = eff_vc1 >= {1'b0, hi_q[2]};
  assign afull_d0  = eff_d0 >= {1'b0, hi_q[3]};
  assign afull_d1  = eff_d1 >= {1'b0, hi_q[4]};

  assign active     = (state_q == StActive);
  assign pop_main_c = active && (main_cnt != '0) && !(main_head_vc ? afull_vc1 : afull_vc0);
  assign pop_vc0_c  = active && (vc0_cnt != '0) && !(vc0_head_dst ? afull_d1 : afull_d0);
  assign pop_vc1_c  = active && !pop_vc0_c && (vc1_cnt != '0) &&
                      !(vc1_head_dst ? afull_d1 : afull_d0);

  assign push_vc0_d = pop_main_c && !main_head_vc;
  assign push_vc1_d = pop_main_c && main_head_vc;
  assign push_d0_d  = (pop_vc0_c && !vc0_head_dst) || (pop_vc1_c && !vc1_head_dst);
  assign push_d1_d  = (pop_vc0_c && vc0_head_dst) || (pop_vc1_c && vc1_head_dst);
  assign push_busy  = push_vc0_q || push_vc1_q || push_d0_q || push_d1_q;

  always_comb begin
    over      = 1'b0;
    all_empty = 1'b1;
    thr_ok    = 1'b1;
    for (int i = 0; i < NumFifo; i++) begin
      lo_d[i] = lo_q[i];
      hi_d[i] = hi_q[i];
      if (state_q == StInit) begin
        lo_d[i] = lo_in[i];
        hi_d[i] = hi_in[i];
      end
      if ({1'b0, cnt[i]} > DepthLim) over = 1'b1;
      if (cnt[i] != '0) all_empty = 1'b0;
      if (lo_in[i] >= hi_in[i]) thr_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:  state_d = StInit;
      StInit:   if (!init) state_d = thr_ok ? StIdle : StError;
      StIdle: begin
        if (over) state_d = StError;
        else if (main_cnt != '0) state_d = StActive;
      end
      StActive: begin
        if (over) state_d = StError;
        else if (all_empty && !push_busy) state_d = StIdle;
      end
      StError:  state_d = StError;
      default:  state_d = StReset;
    endcase
    if (init && (state_q != StReset)) state_d = StInit;
  end

  // Backpressure sets at the high mark and holds until the count falls to the low mark.
  always_comb begin
    pause_d = 1'b0;
    if (state_q != StReset) begin
      pause_d = (main_cnt >= hi_q[0]) || (pause_q && (main_cnt > lo_q[0]));
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q    <= StReset;
      push_vc0_q <= 1'b0;
      push_vc1_q <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      pause_q    <= 1'b0;
      for (int i = 0; i < NumFifo; i++) begin
        lo_q[i] <= '0;
        hi_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      push_vc0_q <= push_vc0_d;
      push_vc1_q <= push_vc1_d;
      push_d0_q  <= push_d0_d;
      push_d1_q  <= push_d1_d;
      pause_q    <= pause_d;
      for (int i = 0; i < NumFifo; i++) begin
        lo_q[i] <= lo_d[i];
        hi_q[i] <= hi_d[i];
      end
    end
  end

  assign pop_main   = pop_main_c;
  assign pop_vc0    = pop_vc0_c;
  assign pop_vc1    = pop_vc1_c;
  assign push_vc0   = push_vc0_q;
  assign push_vc1   = push_vc1_q;
  assign push_d0    = push_d0_q;
  assign push_d1    = push_d1_q;
  assign main_pause = pause_d;
  assign state      = state_q;
  assign idle_out   = (state_q == StIdle);
  assign error_out  = (state_q == StError);

endmodule

// File: tb/tb_tx_flow_ctrl.sv
// Self-checking bench for tx_flow_ctrl: per-cycle expected output vectors queued as stimulus
// is applied, then compared against the sampled outputs on the falling edge.
module tb_tx_flow_ctrl;

  localparam int CW = 5;

  logic clk = 1'b0;
  logic RESET_L, init;
  logic [CW-1:0] main_fifo_low, main_fifo_high, Vco_low, Vco_high, Vc1_low, Vc1_high;
  logic [CW-1:0] Do_low, Do_high, D1_low, D1_high;
  logic [CW-1:0] main_cnt, vc0_cnt, vc1_cnt, d0_cnt, d1_cnt;
  logic main_head_vc, vc0_head_dst, vc1_head_dst;
  logic pop_main, push_vc0, push_vc1, pop_vc0, pop_vc1, push_d0, push_d1;
  logic main_pause, idle_out, error_out;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [12:0] exp;
    logic [12:0] mask;
  } sb_t;
  sb_t sb[$];

  localparam logic [12:0] All     = 13'h1fff;
  localparam logic [12:0] NoPause = 13'h1f7f;

  always #5 clk = ~clk;

  tx_flow_ctrl #(.CNT_W(5), .FIFO_DEPTH(16)) dut (
    .clk(clk), .RESET_L(RESET_L), .init(init),
    .main_fifo_low(main_fifo_low), .main_fifo_high(main_fifo_high),
    .Vco_low(Vco_low), .Vco_high(Vco_high), .Vc1_low(Vc1_low), .Vc1_high(Vc1_high),
    .Do_low(Do_low), .Do_high(Do_high), .D1_low(D1_low), .D1_high(D1_high),
    .main_cnt(main_cnt), .vc0_cnt(vc0_cnt), .vc1_cnt(vc1_cnt), .d0_cnt(d0_cnt),
    .d1_cnt(d1_cnt), .main_head_vc(main_head_vc), .vc0_head_dst(vc0_head_dst),
    .vc1_head_dst(vc1_head_dst), .pop_main(pop_main), .push_vc0(push_vc0),
    .push_vc1(push_vc1), .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0),
    .push_d1(push_d1), .main_pause(main_pause), .state(state), .idle_out(idle_out),
    .error_out(error_out)
  );

  // {state, idle, error, pause, pop_main, push_vc0, push_vc1, pop_vc0, pop_vc1, push_d0, push_d1}
  function automatic logic [12:0] obs_vec();
    return {state, idle_out, error_out, main_pause, pop_main, push_vc0, push_vc1,
            pop_vc0, pop_vc1, push_d0, push_d1};
  endfunction

  function automatic logic [12:0] ev(input logic [2:0] st, input logic [6:0] strb,
                                     input logic pause);
    return {st, st == 3'd2, st == 3'd4, pause, strb};
  endfunction

  task automatic check_eq(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [12:0] e, input logic [12:0] m);
    sb_t it;
    sb.push_back('{tag: tag, exp: e, mask: m});
    @(negedge clk);
    it = sb.pop_front();
    check_eq(it.tag, obs_vec() & it.mask, it.exp & it.mask);
    @(posedge clk);
    #1;
  endtask

  task automatic cnts(input int m, input int v0, input int v1, input int d0, input int d1);
    main_cnt = CW'(m);
    vc0_cnt  = CW'(v0);
    vc1_cnt  = CW'(v1);
    d0_cnt   = CW'(d0);
    d1_cnt   = CW'(d1);
  endtask

  initial begin
    RESET_L = 1'b0;
    init    = 1'b0;
    {main_fifo_low, main_fifo_high, Vco_low, Vco_high, Vc1_low, Vc1_high} = '0;
    {Do_low, Do_high, D1_low, D1_high} = '0;
    cnts(0, 0, 0, 0, 0);
    main_head_vc = 1'b0;
    vc0_head_dst = 1'b0;
    vc1_head_dst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", ev(0, 7'b0, 1'b0), All);

    RESET_L = 1'b1;
    init    = 1'b1;
    main_fifo_low = 5'd1; main_fifo_high = 5'd3;
    Vco_low = 5'd2; Vco_high = 5'd8; Vc1_low = 5'd2; Vc1_high = 5'd8;
    Do_low = 5'd2; Do_high = 5'd9; D1_low = 5'd2; D1_high = 5'd9;
    cyc("reset_release", ev(0, 7'b0, 1'b0), All);
    cyc("init_a", ev(1, 7'b0, 1'b0), NoPause);
    init = 1'b0;
    cyc("init_b", ev(1, 7'b0, 1'b0), NoPause);

    // Single word main -> VC0 -> D1
    cnts(1, 0, 0, 0, 0);
    cyc("idle", ev(2, 7'b0, 1'b0), All);
    cyc("pop_main", ev(3, 7'b1000000, 1'b0), All);
    cnts(0, 0, 0, 0, 0);
    cyc("push_vc0", ev(3, 7'b0100000, 1'b0), All);
    cnts(0, 1, 0, 0, 0);
    vc0_head_dst = 1'b1;
    cyc("pop_vc0", ev(3, 7'b0001000, 1'b0), All);
    cnts(0, 0, 0, 0, 0);
    cyc("push_d1", ev(3, 7'b0000001, 1'b0), All);
    cnts(0, 0, 0, 0, 1);
    cyc("drain", ev(3, 7'b0, 1'b0), All);
    cnts(0, 0, 0, 0, 0);
    cyc("last_active", ev(3, 7'b0, 1'b0), All);

    // VC0 almost-full: one pop, then held
    cnts(2, 7, 0, 0, 9);
    cyc("back_idle", ev(2, 7'b0, 1'b0), All);
    cyc("afull_pop", ev(3, 7'b1000000, 1'b0), All);
    cnts(1, 7, 0, 0, 9);
    cyc("afull_push", ev(3, 7'b0100000, 1'b0), All);
    cnts(1, 8, 0, 0, 9);
    cyc("afull_hold1", ev(3, 7'b0, 1'b0), All);
    cyc("afull_hold2", ev(3, 7'b0, 1'b0), All);
    cnts(1, 7, 0, 0, 9);
    cyc("afull_release", ev(3, 7'b1000000, 1'b0), All);
    cnts(0, 7, 0, 0, 9);
    cyc("afull_push2", ev(3, 7'b0100000, 1'b0), All);

    // VC0 priority on the D side
    cnts(0, 2, 2, 0, 0);
    vc1_head_dst = 1'b1;
    cyc("prio_vc0", ev(3, 7'b0001000, 1'b0), All);
    cnts(0, 0, 2, 0, 0);
    cyc("vc1_next", ev(3, 7'b0000101, 1'b0), All);
    cnts(0, 1, 1, 9, 0);
    vc0_head_dst = 1'b0;
    cyc("vc0_blocked", ev(3, 7'b0000101, 1'b0), All);
    cnts(0, 0, 0, 0, 0);
    cyc("push_d1_b", ev(3, 7'b0000001, 1'b0), All);
    cyc("quiet", ev(3, 7'b0, 1'b0), All);

    // Backpressure hysteresis (pops blocked downstream)
    cnts(3, 8, 0, 9, 0);
    cyc("pause_set", ev(2, 7'b0, 1'b1), All);
    cnts(2, 8, 0, 9, 0);
    cyc("pause_hold", ev(3, 7'b0, 1'b1), All);
    cnts(1, 8, 0, 9, 0);
    cyc("pause_clear", ev(3, 7'b0, 1'b0), All);

    // Over-depth count, then bad thresholds
    cnts(1, 8, 0, 17, 0);
    cyc("over_depth", ev(3, 7'b0, 1'b0), All);
    cnts(0, 0, 0, 0, 0);
    init = 1'b1;
    cyc("error", ev(4, 7'b0, 1'b0), All);
    Do_low = 5'd9; Do_high = 5'd9;
    cyc("reinit", ev(1, 7'b0, 1'b0), All);
    init = 1'b0;
    cyc("bad_thr", ev(1, 7'b0, 1'b0), All);
    init = 1'b1;
    Do_low = 5'd2; Do_high = 5'd9;
    cyc("error_thr", ev(4, 7'b0, 1'b0), All);
    init = 1'b0;
    cyc("init_again", ev(1, 7'b0, 1'b0), All);

    // Async reset in the middle of a push
    cnts(1, 0, 0, 0, 0);
    main_head_vc = 1'b0;
    cyc("idle_again", ev(2, 7'b0, 1'b0), All);
    cyc("pop_main_b", ev(3, 7'b1000000, 1'b0), All);
    cnts(0, 0, 0, 0, 0);
    check_eq("push_before_reset", {12'b0, push_vc0}, 13'd1);
    RESET_L = 1'b0;
    #1;
    check_eq("reset_async", obs_vec(), ev(0, 7'b0, 1'b0));
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
